matmul_mem_master: RTL and testbench
====================================

Name: matmul_mem_master

Overview:
- Memory-side initiator for data_memory_unit: issues read/write requests on its address/read_enable/write_enable/write_data bus and consumes read_data.
- Computes C = A x B for two N x N row-major matrices of 16-bit words held in data memory, then writes C back to data memory.
- Sits beside the non-pipelined MIPS datapath as a matrix-multiply offload engine, started by a single pulse.

Parameters:
- N, 3, matrix dimension (2..15).
- A_BASE, 16'd0, word address of A[0][0].
- B_BASE, 16'd9, word address of B[0][0].
- C_BASE, 16'd18, word address of C[0][0].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle start pulse; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE on the next edge.
- address  output  16  memory word address.
- write_data  output  16  data for a memory write.
- write_enable  output  1  memory write strobe; memory writes on the same rising edge.
- read_enable  output  1  memory read strobe.
- read_data  input  16  memory read data, combinational from address when read_enable=1.
- busy  output  1  high from the first RD_A cycle through the last WR cycle.
- done  output  1  one-cycle completion pulse.

Behaviour:
- All outputs are Moore-decoded from registered state and counters (i, j, k, a_reg, acc).
- Reset values: address=0, write_data=0, write_enable=0, read_enable=0, busy=0, done=0; state=IDLE; i=j=k=0; acc=0; a_reg=0.
- States: IDLE, RD_A, RD_B, WR, DONE.
- IDLE:
  - start=1 -> RD_A; clear i, j, k and acc.
  - All other inputs are ignored.
- RD_A:
  - Drive read_enable=1, address=A_BASE+i*N+k.
  - Capture a_reg<=read_data, then go to RD_B.
- RD_B:
  - Drive read_enable=1, address=B_BASE+k*N+j.
  - Update acc<=acc+a_reg*read_data.
  - If k<N-1: k++ and go to RD_A. Otherwise go to WR.
- WR:
  - Drive write_enable=1, address=C_BASE+i*N+j, write_data=acc[15:0].
  - Clear acc and k.
  - Advance j; when j wraps to 0, advance i.
  - Last element (i=N-1, j=N-1) -> DONE; otherwise -> RD_A.
- DONE: assert done=1 for one cycle -> IDLE.
- read_enable and write_enable are never high in the same cycle.
- Both strobes are low in IDLE and DONE.
- Arithmetic:
  - Product is unsigned 16x16 -> 32 bits; acc is 32 bits and wraps modulo 2^32.
  - The stored result is truncated to acc[15:0].
  - Address sums are 16-bit and wrap modulo 2^16.
- Latency:
  - Each C element takes 2N+1 cycles; the whole job takes N*N*(2N+1) cycles.
  - For N=3: start sampled at edge 0, first RD_A in cycle 1, last WR in cycle 63, done in cycle 64.
- start while busy: ignored; no restart, no queueing.
- abort=1 in any non-IDLE state -> IDLE on the next edge.
  - No done pulse is generated.
  - If abort coincides with WR, that write still occurs (the strobe is already asserted for the edge).
  - C elements already written remain.
- reset_n low mid-operation:
  - All outputs drop to reset values immediately (asynchronously).
  - No further write occurs while reset_n is low.
  - Partial C in memory is left unchanged.
- start and abort both high in IDLE: abort wins; the block stays in IDLE.

Decomposition:
- matmul_pkg holds:
  - the state encoding constants (IDLE..DONE);
  - the default base addresses;
  - the data, address and accumulator widths (16/16/32).
- One sub-module, matmul_addr_gen: purely combinational; computes the A, B and C addresses from i, j, k, N and the bases.
- The FSM, counters and MAC stay in the top module.

Test Plan:
- Default memory image (A and B rows = 1,2,3), N=3, pulse start -> words 18..26 become 6,12,18,6,12,18,6,12,18; done pulses exactly in cycle 64; busy is high in cycles 1..63.
- Bus protocol check across a full job:
  - exactly 54 read cycles and 9 write cycles;
  - never read_enable and write_enable together;
  - first read address is 0, then 9;
  - first write is address 18, data 6.
- Overflow: all 18 A/B words = 16'hFFFF -> every C word = 16'h0003.
- start re-pulsed in cycle 20 -> ignored; the result and done timing are identical to the first test.
- abort in cycle 10 -> IDLE next cycle; done never pulses; only word 18 (=6) has been written. A subsequent start runs the full job correctly.
- reset_n driven low in cycle 30 for 2 cycles -> all outputs 0 during reset; no write while low; afterwards IDLE, busy=0; a fresh start completes normally.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared widths, default base addresses and FSM encoding for the matrix-multiply
// memory master.
package matmul_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int ACC_W  = 32;
    // Wide enough for indices 0..14 (N up to 15).
    localparam int CNT_W  = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ACC_W-1:0]  acc_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam addr_t DEF_A_BASE = 16'd0;
    localparam addr_t DEF_B_BASE = 16'd9;
    localparam addr_t DEF_C_BASE = 16'd18;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/matmul_addr_gen.sv
// Combinational word-address generator for row-major A[i][k], B[k][j] and C[i][j].
module matmul_addr_gen
    import matmul_pkg::*;
#(
    parameter int    N      = 3,
    parameter addr_t A_BASE = DEF_A_BASE,
    parameter addr_t B_BASE = DEF_B_BASE,
    parameter addr_t C_BASE = DEF_C_BASE
) (
    input  cnt_t  i,
    input  cnt_t  j,
    input  cnt_t  k,
    output addr_t a_addr,
    output addr_t b_addr,
    output addr_t c_addr
);

    localparam addr_t N_W = addr_t'(N);

    // All sums are 16-bit and wrap naturally modulo 2^16.
    assign a_addr = A_BASE + addr_t'(i) * N_W + addr_t'(k);
    assign b_addr = B_BASE + addr_t'(k) * N_W + addr_t'(j);
    assign c_addr = C_BASE + addr_t'(i) * N_W + addr_t'(j);

endmodule

// File: rtl/matmul_mem_master.sv
// Matrix-multiply offload engine: reads A and B from data memory one word per
// cycle, accumulates each dot product and writes C back, all Moore-decoded.
module matmul_mem_master
    import matmul_pkg::*;
#(
    parameter int    N      = 3,
    parameter addr_t A_BASE = DEF_A_BASE,
    parameter addr_t B_BASE = DEF_B_BASE,
    parameter addr_t C_BASE = DEF_C_BASE
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  start,
    input  logic  abort,
    output addr_t address,
    output data_t write_data,
    output logic  write_enable,
    output logic  read_enable,
    input  data_t read_data,
    output logic  busy,
    output logic  done
);

    localparam cnt_t LAST = cnt_t'(N - 1);

    state_t state, next_state;
    cnt_t   i, j, k;
    data_t  a_reg;
    acc_t   acc;
    addr_t  a_addr, b_addr, c_addr;

    matmul_addr_gen #(
        .N      (N),
        .A_BASE (A_BASE),
        .B_BASE (B_BASE),
        .C_BASE (C_BASE)
    ) u_addr_gen (
        .i      (i),
        .j      (j),
        .k      (k),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .c_addr (c_addr)
    );

    // NOTE: every register here uses <= so all updates see pre-edge values;
    // a_reg and acc are plain registers, so resetting them costs nothing and
    // keeps post-reset state fully defined.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            a_reg <= '0;
            acc   <= '0;
        end else begin
            state <= next_state;
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        acc <= '0;
                    end
                end
                RD_A: a_reg <= read_data;
                RD_B: begin
                    // 16x16 product fits 32 bits; the running sum wraps mod 2^32.
                    acc <= acc + acc_t'(a_reg) * acc_t'(read_data);
                    if (k != LAST) begin
                        k <= k + 1'b1;
                    end
                end
                WR: begin
                    acc <= '0;
                    k   <= '0;
                    if (j == LAST) begin
                        j <= '0;
                        i <= (i == LAST) ? '0 : i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned
    // (which would infer a latch).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start && !abort) next_state = RD_A;
            RD_A:    next_state = RD_B;
            RD_B:    next_state = (k == LAST) ? WR : RD_A;
            WR:      next_state = (i == LAST && j == LAST) ? DONE : RD_A;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort && state != IDLE) begin
            next_state = IDLE;
        end
    end

    // Strobes come straight from state, so an abort during WR still writes.
    always_comb begin
        address      = '0;
        write_data   = '0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        done         = 1'b0;
        unique case (state)
            RD_A: begin
                read_enable = 1'b1;
                address     = a_addr;
            end
            RD_B: begin
                read_enable = 1'b1;
                address     = b_addr;
            end
            WR: begin
                write_enable = 1'b1;
                address      = c_addr;
                write_data   = acc[DATA_W-1:0];
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state == RD_A) || (state == RD_B) || (state == WR);

endmodule

// File: tb/tb_matmul_mem_master.sv
// Self-checking bench: table of full 3x3 jobs plus restart, abort and reset
// sequences against a behavioural data memory.
module tb_matmul_mem_master;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] address;
    logic [15:0] write_data;
    logic        write_enable;
    logic        read_enable;
    logic [15:0] read_data;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:255];

    int total;
    int passed;

    int n_rd, n_wr, n_both, n_busy, busy_first, busy_last, late_busy;
    int done_cnt, done_cyc;
    logic [15:0] first_rd0, first_rd1, first_wr_addr, first_wr_data;

    typedef struct {
        logic [0:8][15:0] a;
        logic [0:8][15:0] b;
        logic [0:8][15:0] c;
    } vec_t;

    vec_t vecs [4];

    matmul_mem_master dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .address      (address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign read_data = read_enable ? mem[address[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (write_enable) mem[address[7:0]] <= write_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic load_mem(input vec_t v);
        for (int idx = 0; idx < 256; idx++) mem[idx] = 16'h0000;
        for (int idx = 0; idx < 9; idx++) begin
            mem[idx]     = v.a[idx];
            mem[9 + idx] = v.b[idx];
        end
    endtask

    // Pulses start, then samples every cycle (cycle 1 follows the edge that samples start).
    task automatic run_job(input int repulse, input int abort_c, input int rst_c, input int stop_c);
        n_rd = 0; n_wr = 0; n_both = 0; n_busy = 0; late_busy = 0;
        busy_first = -1; busy_last = -1; done_cnt = 0; done_cyc = -1;
        first_rd0 = 16'hFFFF; first_rd1 = 16'hFFFF;
        first_wr_addr = 16'hFFFF; first_wr_data = 16'hFFFF;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= stop_c; cyc++) begin
            @(negedge clk);
            start = (cyc == repulse);
            abort = (cyc == abort_c);
            if (rst_c > 0 && cyc == rst_c)     reset_n = 1'b0;
            if (rst_c > 0 && cyc == rst_c + 2) reset_n = 1'b1;
            #1;
            if (!reset_n)
                check($sformatf("outs_in_reset_c%0d", cyc),
                      {address, write_data, write_enable, read_enable, busy, done}, '0);
            if (read_enable) begin
                if (n_rd == 0) first_rd0 = address;
                else if (n_rd == 1) first_rd1 = address;
                n_rd++;
            end
            if (write_enable) begin
                if (n_wr == 0) begin
                    first_wr_addr = address;
                    first_wr_data = write_data;
                end
                n_wr++;
            end
            if (read_enable && write_enable) n_both++;
            if (busy) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
                n_busy++;
                if ((abort_c > 0 && cyc > abort_c) || (rst_c > 0 && cyc >= rst_c + 2)) late_busy++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 2) break;
        end
        start = 1'b0;
        abort = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic check_full(input string tag, input vec_t v);
        for (int idx = 0; idx < 9; idx++)
            check($sformatf("%s_c%0d", tag, idx), mem[18 + idx], v.c[idx]);
        check({tag, "_done_cyc"}, done_cyc, 64);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_cnt"}, n_busy, 63);
        check({tag, "_busy_first"}, busy_first, 1);
        check({tag, "_busy_last"}, busy_last, 63);
        check({tag, "_reads"}, n_rd, 54);
        check({tag, "_writes"}, n_wr, 9);
        check({tag, "_rd_wr_overlap"}, n_both, 0);
        check({tag, "_first_rd0"}, first_rd0, 16'd0);
        check({tag, "_first_rd1"}, first_rd1, 16'd9);
        check({tag, "_first_wr_addr"}, first_wr_addr, 16'd18);
        check({tag, "_first_wr_data"}, first_wr_data, v.c[0]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        passed = 0;

        // A and B rows 1,2,3: C[i][j] = 6*(j+1).
        vecs[0].a = {16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd3};
        vecs[0].b = {16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd3};
        vecs[0].c = {16'd6, 16'd12, 16'd18, 16'd6, 16'd12, 16'd18, 16'd6, 16'd12, 16'd18};
        // 3 * 0xFFFE0001 = 0x2_FFFA_0003 -> low half 0x0003.
        vecs[1].a = {9{16'hFFFF}};
        vecs[1].b = {9{16'hFFFF}};
        vecs[1].c = {9{16'h0003}};
        // Identity times B gives B.
        vecs[2].a = {16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
        vecs[2].b = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        vecs[2].c = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        // [1..9] squared.
        vecs[3].a = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        vecs[3].b = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        vecs[3].c = {16'd30, 16'd36, 16'd42, 16'd66, 16'd81, 16'd96, 16'd102, 16'd126, 16'd150};

        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        load_mem(vecs[0]);
        #12;
        check("reset_outputs", {address, write_data, write_enable, read_enable, busy, done}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_after_reset", {write_enable, read_enable, busy, done}, '0);

        for (int t = 0; t < 4; t++) begin
            load_mem(vecs[t]);
            run_job(0, 0, 0, 150);
            check_full($sformatf("vec%0d", t), vecs[t]);
        end

        // start re-pulsed while busy must change nothing.
        load_mem(vecs[0]);
        run_job(20, 0, 0, 150);
        check_full("repulse", vecs[0]);

        // Abort mid-job: only the first C word survives, no done.
        load_mem(vecs[0]);
        run_job(0, 10, 0, 80);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_writes", n_wr, 1);
        check("abort_late_busy", late_busy, 0);
        check("abort_c0", mem[18], 16'd6);
        check("abort_c1", mem[19], 16'd0);
        load_mem(vecs[0]);
        run_job(0, 0, 0, 150);
        check_full("after_abort", vecs[0]);

        // Reset low for cycles 30..31: elements 0..3 remain, nothing else written.
        load_mem(vecs[0]);
        run_job(0, 0, 30, 80);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_late_busy", late_busy, 0);
        check("rst_writes", n_wr, 4);
        check("rst_c3", mem[21], 16'd6);
        check("rst_c4", mem[22], 16'd0);
        load_mem(vecs[0]);
        run_job(0, 0, 0, 150);
        check_full("after_reset", vecs[0]);

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("start_abort_busy", {busy, read_enable}, 2'b00);
        @(negedge clk);
        #1;
        check("start_abort_busy_next", {busy, read_enable}, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
